apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
Round-robin APB master that shares one APB slave port (`APB_Slave`-class completer) between NUM_REQ local requesters. It accepts one request at a time and runs the APB SETUP/ACCESS sequence, honouring PREADY wait states. It returns read data and a completion pulse to the requester that issued the transfer. It sits between bus-side initiators (DMA, CPU bridge, config sequencer) and the APB slave interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 8, APB address width (matches `ADDRWIDTH)
DATA_W, 32, APB data width (matches `DATAWIDTH)
TIMEOUT_CYC, 16, PREADY wait limit in ACCESS cycles (used only with APB_TIMEOUT_EN)

Ports:
PCLK  in  1  clock; all logic on rising edge
PRESET  in  1  reset, synchronous, active-high
req_valid  in  NUM_REQ  per-requester request
req_write  in  NUM_REQ  per-requester direction, 1 = write
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing
req_ready  out  NUM_REQ  one-hot accept pulse
rsp_valid  out  NUM_REQ  one-hot completion pulse
rsp_rdata  out  DATA_W  read data, shared
rsp_err  out  1  error flag, qualified by any rsp_valid
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready

Behaviour:
- Clock and reset: one clock, PCLK; reset PRESET is synchronous and active-high.
- All outputs are registered. While PRESET=1: all outputs 0, state=IDLE, last_grant=NUM_REQ-1 so requester 0 wins first.
- States:
  - IDLE: PSEL=0, PENABLE=0.
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
- Arbitration: runs in IDLE, and in ACCESS on the completing cycle (PREADY=1).
  - Winner g = first asserted req_valid scanning from last_grant+1 upward, with wrap-around.
  - On the same edge: req_ready[g] pulses 1 cycle; addr, wdata and write of g are latched onto PADDR/PWDATA/PWRITE; last_grant<=g; next state SETUP.
- No req_valid in IDLE: stay in IDLE. A requester may drop req_valid before acceptance with no side effect. After req_ready it must not reissue until its rsp_valid.
- SETUP to ACCESS: unconditional after 1 cycle.
- ACCESS with PREADY=0: hold. PADDR, PWDATA and PWRITE stay stable from SETUP until completion.
- ACCESS with PREADY=1 (completion):
  - rsp_valid[g] pulses 1 cycle; rsp_err=0.
  - Read: rsp_rdata<=PRDATA. Write: rsp_rdata holds its previous value.
  - Then: if any req_valid, go back-to-back into SETUP (PSEL stays 1, PENABLE=0) with the new grant; otherwise go to IDLE.
- Timing: minimum transfer is 2 cycles (SETUP+ACCESS). Sustained zero-wait throughput is 1 transfer per 2 cycles.
- Latency: rsp_valid appears 2+W cycles after the req_ready pulse, where W = number of PREADY=0 wait cycles.
- Fairness: with all requesters active, grants rotate 0,1,2,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transfers.
- Reset mid-transfer: next edge PSEL=PENABLE=0. No rsp_valid is issued for the aborted transfer. Arbitration restarts at requester 0.
- PREADY outside ACCESS: ignored.

Optional Feature:
APB_TIMEOUT_EN
- Defined:
  - A wait counter is cleared on entering ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYC, the transfer aborts: rsp_valid[g] pulses with rsp_err=1 and rsp_rdata=0, PSEL=PENABLE=0, state=IDLE. No back-to-back transfer follows on the abort cycle.
- Undefined: ACCESS waits indefinitely for PREADY; rsp_err is constant 0.

Test Plan:
1. Single write: req 0 write addr 0x10 data 0xDEADBEEF, PREADY=1 -> req_ready[0] pulse; SETUP with PADDR=0x10, PWRITE=1; ACCESS next cycle; rsp_valid[0] 2 cycles after accept, rsp_err=0.
2. Read with 3 wait states: req 1 read 0x10, PREADY low for 3 ACCESS cycles, PRDATA=0xDEADBEEF -> PENABLE high 4 cycles, PADDR stable throughout; rsp_valid[1] with rsp_rdata=0xDEADBEEF.
3. Contention: all 4 requesters assert together, zero wait -> grant order 0,1,2,3; PSEL continuously 1; one completion every 2 cycles; 8 cycles total.
4. Round-robin rotation: after serving req 2, reqs 0 and 3 assert -> req 3 served before req 0.
5. Reset mid-ACCESS: PRESET=1 during ACCESS with PREADY=0 -> next edge all outputs 0, no rsp_valid; first request after reset release is served normally.
6. Timeout (APB_TIMEOUT_EN, TIMEOUT_CYC=16): PREADY held 0 -> rsp_valid with rsp_err=1, rsp_rdata=0 after 16 ACCESS cycles; PSEL=0 next cycle. Without the macro: still in ACCESS at cycle 100.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin APB master sharing one completer among NUM_REQ requesters.
// Define APB_TIMEOUT_EN to abort an ACCESS after TIMEOUT_CYC PREADY-low cycles with rsp_err.
module apb_master_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PREADY
);
    localparam int GW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state, nxt;
    logic [GW-1:0] last_grant, cur, win;
    logic found, done, abort, grant;

    // Rotating priority: first valid requester after last_grant, wrapping around.
    always_comb begin
        int idx;
        idx = 0;
        found = 1'b0;
        win = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant) + k - ((int'(last_grant) + k >= NUM_REQ) ? NUM_REQ : 0);
            if (!found && req_valid[GW'(idx)]) begin
                found = 1'b1;
                win = GW'(idx);
            end
        end
    end

    assign done  = state == ACCESS && PREADY;
    assign grant = found && (state == IDLE || done);

`ifdef APB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] wcnt;
    assign abort = state == ACCESS && !PREADY && wcnt == WW'(TIMEOUT_CYC - 1);
    always_ff @(posedge PCLK) begin
        if (PRESET || state != ACCESS) wcnt <= '0;
        else if (!PREADY) wcnt <= wcnt + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign abort = 1'b0;
`endif

    always_comb begin
        nxt = state == IDLE  ? (found ? SETUP : IDLE)
            : state == SETUP ? ACCESS
            : abort          ? IDLE
            : PREADY         ? (found ? SETUP : IDLE)
            : ACCESS;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) state <= IDLE;
        else state <= nxt;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            last_grant <= GW'(NUM_REQ - 1);
            cur        <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
        end else begin
            PSEL      <= nxt != IDLE;
            PENABLE   <= nxt == ACCESS;
            req_ready <= grant ? NUM_REQ'(1) << win : '0;
            rsp_valid <= (done || abort) ? NUM_REQ'(1) << cur : '0;
            rsp_err   <= abort;
            rsp_rdata <= abort ? '0 : (done && !PWRITE) ? PRDATA : rsp_rdata;
            if (grant) begin
                cur        <= win;
                last_grant <= win;
                PWRITE     <= req_write[win];
                PADDR      <= req_addr[win*ADDR_W +: ADDR_W];
                PWDATA     <= req_wdata[win*DATA_W +: DATA_W];
            end
        end
    end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: scoreboard bench; responses expected in issue order, slave returns address-derived data.
module tb_apb_master_arbiter;
    localparam int N = 4, AW = 8, DW = 32, TO = 16;

    logic PCLK = 1'b0, PRESET = 1'b1;
    logic [N-1:0] req_valid = '0, req_write = '0, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [DW-1:0] rsp_rdata, PWDATA, PRDATA;
    logic [AW-1:0] PADDR;
    logic rsp_err, PSEL, PENABLE, PWRITE, PREADY;

    typedef struct {
        int idx;
        logic wr;
        logic [AW-1:0] addr;
        logic err;
        int lat;
    } rsp_t;

    rsp_t sb[$];
    int gq[$];
    int rsp_cyc[$];
    int checks = 0, failures = 0, cyc = 0, wait_n = 0, acnt = 0, en_cnt = 0, psel_cnt = 0, cur_g = 0;
    int acc_cyc[N];
    logic [AW-1:0] a_addr[N];
    logic [DW-1:0] a_wdata[N];
    logic a_wr[N];
    logic [DW-1:0] last_rd = '0;

    apb_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    function automatic logic [DW-1:0] slave_rd(input logic [AW-1:0] a);
        return 32'hDEADBEEF ^ {24'h0, a ^ 8'h10};
    endfunction

    // Completer: inserts wait_n wait states per ACCESS.
    assign PRDATA = slave_rd(PADDR);
    assign PREADY = PSEL && PENABLE && (acnt >= wait_n);
    always @(posedge PCLK) acnt <= (PSEL && PENABLE && !PREADY) ? acnt + 1 : 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic monitor();
        rsp_t e;
        logic [DW-1:0] exp_rd;
        if (PSEL && PENABLE) en_cnt++;
        if (PSEL) psel_cnt++;
        if (|req_ready) begin
            if (gq.size() == 0) chk("grant_spurious", 64'(req_ready), 0);
            else begin
                cur_g = gq.pop_front();
                chk("grant", 64'(req_ready), 64'(1) << cur_g);
                req_valid[cur_g] = 1'b0;
                acc_cyc[cur_g] = cyc;
            end
        end
        if (PSEL && !PENABLE) begin
            chk("setup_addr", 64'(PADDR), 64'(a_addr[cur_g]));
            chk("setup_write", 64'(PWRITE), 64'(a_wr[cur_g]));
            if (a_wr[cur_g]) chk("setup_wdata", 64'(PWDATA), 64'(a_wdata[cur_g]));
        end
        if (PSEL && PENABLE) chk("access_addr", 64'(PADDR), 64'(a_addr[cur_g]));
        if (|rsp_valid) begin
            if (sb.size() == 0) chk("rsp_spurious", 64'(rsp_valid), 0);
            else begin
                e = sb.pop_front();
                exp_rd = e.err ? '0 : e.wr ? last_rd : slave_rd(e.addr);
                last_rd = exp_rd;
                chk("rsp_idx", 64'(rsp_valid), 64'(1) << e.idx);
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
                chk("rsp_lat", 64'(cyc - acc_cyc[e.idx]), 64'(e.lat));
                chk("rsp_penable_cycles", 64'(en_cnt), 64'(e.lat - 1));
                if (e.err) chk("abort_psel", 64'(PSEL), 0);
                rsp_cyc.push_back(cyc);
            end
            en_cnt = 0;
        end
    endtask

    task automatic step();
        @(negedge PCLK);
        if (!PRESET) monitor();
        @(posedge PCLK);
        #1;
        cyc++;
    endtask

    task automatic issue(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic err, input int lat);
        rsp_t e;
        req_valid[i] = 1'b1;
        req_write[i] = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        a_addr[i] = a;
        a_wr[i] = wr;
        a_wdata[i] = d;
        e.idx = i;
        e.wr = wr;
        e.addr = a;
        e.err = err;
        e.lat = lat;
        sb.push_back(e);
        gq.push_back(i);
    endtask

    task automatic drain(input int bound);
        for (int k = 0; k < bound && sb.size() != 0; k++) step();
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 0);
    endtask

    task automatic do_reset(input int n);
        PRESET = 1'b1;
        req_valid = '0;
        repeat (n) step();
        chk("rst_psel", 64'(PSEL), 0);
        chk("rst_penable", 64'(PENABLE), 0);
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_rsp_err", 64'(rsp_err), 0);
        chk("rst_paddr", 64'(PADDR), 0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 0);
        PRESET = 1'b0;
        sb.delete();
        gq.delete();
        en_cnt = 0;
        last_rd = '0;
        cur_g = 0;
    endtask

    initial begin
        do_reset(3);
        // Single zero-wait write, then a read with 3 wait states.
        wait_n = 0;
        issue(0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 2);
        drain(20);
        wait_n = 3;
        issue(1, 1'b0, 8'h10, '0, 1'b0, 5);
        drain(20);
        // After serving 2, requesters 3 and 0 together: 3 wins first.
        wait_n = 0;
        issue(2, 1'b1, 8'h22, 32'h2222_0000, 1'b0, 2);
        drain(20);
        issue(3, 1'b0, 8'h33, '0, 1'b0, 2);
        issue(0, 1'b1, 8'h30, 32'h0000_3030, 1'b0, 2);
        drain(30);
        // Leave last_grant at 3, then full contention rotates 0,1,2,3 back-to-back.
        issue(3, 1'b0, 8'h40, '0, 1'b0, 2);
        drain(20);
        psel_cnt = 0;
        rsp_cyc.delete();
        for (int i = 0; i < N; i++) issue(i, i[0], 8'h80 + 8'(i), 32'hA000_0000 + i, 1'b0, 2);
        drain(40);
        chk("b2b_psel_cycles", 64'(psel_cnt), 8);
        chk("b2b_rsp_count", 64'(rsp_cyc.size()), 4);
        if (rsp_cyc.size() == 4) chk("b2b_rsp_span", 64'(rsp_cyc[3] - rsp_cyc[0]), 6);
        // Reset in the middle of a stalled ACCESS; arbitration restarts at requester 0.
        wait_n = 1000;
        issue(2, 1'b0, 8'h55, '0, 1'b0, 2);
        for (int k = 0; k < 10 && !(PSEL && PENABLE); k++) step();
        chk("mid_access_reached", 64'(PSEL && PENABLE), 1);
        step();
        do_reset(1);
        wait_n = 0;
        issue(0, 1'b1, 8'h60, 32'h0000_6060, 1'b0, 2);
        issue(2, 1'b0, 8'h61, '0, 1'b0, 2);
        drain(30);
`ifdef APB_TIMEOUT_EN
        wait_n = 1000;
        issue(1, 1'b0, 8'h44, '0, 1'b1, TO + 1);
        drain(60);
        wait_n = 0;
        step();
        chk("timeout_idle", 64'(PSEL), 0);
`else
        wait_n = 1000;
        issue(1, 1'b0, 8'h44, '0, 1'b0, 0);
        repeat (100) step();
        chk("stall_access", 64'(PSEL && PENABLE), 1);
        chk("stall_no_rsp", 64'(sb.size()), 1);
        do_reset(1);
        wait_n = 0;
`endif
        issue(1, 1'b0, 8'h11, '0, 1'b0, 2);
        drain(20);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
